surf_cin_framer: RTL and testbench
==================================

# surf_cin_framer

Multi-channel, parametrised successor to the single-SURF CIN command path. It accepts commands through per-channel valid/ready handshakes and a broadcast port, each with one buffered slot per channel. Commands are framed on a shared sync-aligned phase counter, with per-channel training override and polarity inversion. The output is one parallel slice per channel per `sysclk_i` cycle, which feeds the external 4:1 OSERDES/OBUFDS layer in the TURFIO SURF-side datapath.

## Interface
Parameters:
- `NCH`, 7: number of SURF channels.
- `CMD_WIDTH`, 32: command bits per frame.
- `BITS_PER_CLK`, 4: bits per channel per `sysclk_i`. `CMD_WIDTH % BITS_PER_CLK == 0` is required; elaboration error otherwise.
- `CIN_INV`, `{NCH{1'b0}}`: per-channel output inversion mask.

Ports:
- `sysclk_i` in 1: the single clock for the block.
- `rst_n_i` in 1: synchronous, active-low reset.
- `sync_i` in 1: frame-align strobe.
- `train_i` in NCH: per-channel training override.
- `cmd_valid_i` in NCH: per-channel command valid.
- `cmd_data_i` in NCH*CMD_WIDTH: per-channel command; channel c occupies `[c*CMD_WIDTH +: CMD_WIDTH]`.
- `cmd_ready_o` out NCH: per-channel ready.
- `bcast_valid_i` in 1: broadcast command valid.
- `bcast_data_i` in CMD_WIDTH: broadcast command.
- `bcast_ready_o` out 1: broadcast ready.
- `frame_start_o` out 1: high on the cycle the first slice of a frame is on `dout_o`.
- `dout_o` out NCH*BITS_PER_CLK: channel c occupies `[c*BITS_PER_CLK +: BITS_PER_CLK]`; LSB is serialised first.

## Operation
- `FRAME_LEN = CMD_WIDTH/BITS_PER_CLK` (8 by default). `LAST = FRAME_LEN-1`.
- Phase counter:
  - `sync_i` forces phase to 1 on the next cycle, so the sync cycle counts as phase 0.
  - Otherwise the counter increments and wraps `LAST -> 0`.
- Per channel there is a `pending` slot (valid flag plus data) and a `hold` shift register.
- Load cycle (phase == LAST), applied per channel in this priority order:
  - `train_i[c]=1`: `hold <= TRAIN_VALUE`. `pending` is not consumed.
  - Else if `pending` is valid: `hold <= pending`, and `pending` is cleared.
  - Else if an accept occurs this same cycle: `hold <=` the accepted data (bypass). `pending` stays empty.
  - Else: `hold <= IDLE_VALUE` (0).
- Non-load cycles: `hold <= {BITS_PER_CLK zeros, hold[CMD_WIDTH-1:BITS_PER_CLK]}`.
- `dout_o` slice = `hold[BITS_PER_CLK-1:0] ^ {BITS_PER_CLK{CIN_INV[c]}}`.
- Channel drain signal: `drain[c] = (phase==LAST) & pending[c] & ~train_i[c]`.
- `cmd_ready_o[c] = (~pending[c] | drain[c]) & ~bcast_valid_i`. Broadcast has priority; when `bcast_valid_i` is high all per-channel ready outputs drop.
- `bcast_ready_o = &(~pending | drain)`. On an accept, the broadcast data is written to every channel's `pending` (or bypassed, per the rule above).
- Each valid/ready handshake is consumed exactly once. A command is never dropped or duplicated.
- Training on a channel stalls its queue. The `pending` slot is kept, and `cmd_ready_o[c]` stays low while the slot is full.

## Timing
- Reset values:
  - phase = 0.
  - All `pending` slots empty.
  - `hold` = 0.
  - `dout_o` = inversion mask replicated per slice.
  - `cmd_ready_o` = 0 and `bcast_ready_o` = 0 while `rst_n_i` is low. Ready outputs are valid from the first cycle after reset is released.
  - `frame_start_o` = 0.
- Latency:
  - A command accepted at cycle t with an empty queue and phase != LAST appears on `dout_o` starting the cycle after the next phase-LAST cycle.
  - A command accepted on a phase-LAST cycle appears at t+1 (bypass).
- `frame_start_o` is high on phase 0.
- `sync_i` mid-frame: the current frame is truncated. `hold` keeps shifting zeros until the realigned LAST. `pending` is unaffected.
- `sync_i` on a LAST cycle: the load still happens, and the phase goes to 1.
- Reset mid-frame: everything returns to the reset values on the next edge, and pending commands are discarded.

## Configuration
- `SURF_CIN_FRAMER_COUNT_EN` defined:
  - Adds output `cmd_count_o` (NCH*16).
  - Each channel has a 16-bit counter that wraps and increments on every non-idle, non-train load.
  - Counters reset to 0.
- Not defined: the port and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `surf_cin_pkg` holds:
  - `TRAIN_VALUE = 32'hA55A6996`.
  - `IDLE_VALUE = 0`.
  - A function `frame_len(cmd_width, bits_per_clk)`.
- Sub-module `surf_cin_chan`: holds the pending slot, load mux, hold shifter and optional counter. It is generated NCH times.
- The phase counter, broadcast logic and ready logic sit in the top level.

## Test plan
- Reset, then `sync_i` pulse with all inputs idle: `dout_o` = 0 (mask 0), and `frame_start_o` is high every 8th cycle starting 1 cycle after the sync cycle's LAST.
- `cmd_valid_i[2]` with `0x12345678` at phase 3: `ready` goes high then low. Channel 2 outputs slices 8,7,6,5,4,3,2,1 after the next LAST; the other channels stay 0.
- `train_i[0]=1` with a command pending on ch0: ch0 outputs `6,9,9,6,A,5,5,A` every frame and `cmd_ready_o[0]` stays 0. After `train_i` drops, the pending command is sent once.
- Broadcast `0xDEADBEEF` with all channels empty: all 7 channels output it in the same frame. A simultaneous `cmd_valid_i[4]` is not accepted that cycle.
- `sync_i` at phase 4 during a command: the frame is truncated with the upper nibbles zeroed, the next load happens 7 cycles later, and the queued command is intact.
- `CIN_INV=7'b0000010`, idle: channel 1 outputs `0xF` each cycle. With `SURF_CIN_FRAMER_COUNT_EN`, after 3 commands `cmd_count_o[ch1]` = 3.

Source files
------------

// File: rtl/surf_cin_pkg.sv
// Shared constants and helpers for the SURF CIN framer.
package surf_cin_pkg;

  localparam logic [31:0] TRAIN_VALUE = 32'hA55A6996;
  localparam logic [31:0] IDLE_VALUE  = 32'h0000_0000;

  function automatic int frame_len(input int cmd_width, input int bits_per_clk);
    return cmd_width / bits_per_clk;
  endfunction

endpackage

// File: rtl/surf_cin_chan.sv
// One CIN channel: pending slot, frame load mux, LSB-first hold shifter.
// Optional per-channel load counter under SURF_CIN_FRAMER_COUNT_EN.
module surf_cin_chan
  import surf_cin_pkg::*;
#(
  parameter int   CMD_WIDTH    = 32,
  parameter int   BITS_PER_CLK = 4,
  parameter logic INV          = 1'b0
) (
  input  logic                    sysclk_i,
  input  logic                    rst_n_i,
  input  logic                    load,
  input  logic                    train,
  input  logic                    wr_en,
  input  logic [CMD_WIDTH-1:0]    wr_data,
  output logic                    pend_valid,
  output logic [BITS_PER_CLK-1:0] slice
`ifdef SURF_CIN_FRAMER_COUNT_EN
  ,
  output logic [15:0]             count
`endif
);

  logic [CMD_WIDTH-1:0] pend_data;
  logic [CMD_WIDTH-1:0] hold;

  // Training parks the queue: a write can still fill an empty slot, nothing drains.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      hold       <= '0;
    end else if (load) begin
      if (train) begin
        hold <= CMD_WIDTH'(TRAIN_VALUE);
        if (wr_en) begin
          pend_valid <= 1'b1;
          pend_data  <= wr_data;
        end
      end else if (pend_valid) begin
        hold       <= pend_data;
        pend_valid <= wr_en;
        if (wr_en) pend_data <= wr_data;
      end else if (wr_en) begin
        hold <= wr_data;
      end else begin
        hold <= CMD_WIDTH'(IDLE_VALUE);
      end
    end else begin
      hold <= hold >> BITS_PER_CLK;
      if (wr_en) begin
        pend_valid <= 1'b1;
        pend_data  <= wr_data;
      end
    end
  end

  assign slice = hold[BITS_PER_CLK-1:0] ^ {BITS_PER_CLK{INV}};

`ifdef SURF_CIN_FRAMER_COUNT_EN
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (load && !train && (pend_valid || wr_en)) begin
      count <= count + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/surf_cin_framer.sv
// Multi-channel CIN command framer: shared sync-aligned phase, per-channel and
// broadcast command slots. Optional counters under SURF_CIN_FRAMER_COUNT_EN.
module surf_cin_framer
  import surf_cin_pkg::*;
#(
  parameter int             NCH          = 7,
  parameter int             CMD_WIDTH    = 32,
  parameter int             BITS_PER_CLK = 4,
  parameter logic [NCH-1:0] CIN_INV      = '0
) (
  input  logic                        sysclk_i,
  input  logic                        rst_n_i,
  input  logic                        sync_i,
  input  logic [NCH-1:0]              train_i,
  input  logic [NCH-1:0]              cmd_valid_i,
  input  logic [NCH*CMD_WIDTH-1:0]    cmd_data_i,
  output logic [NCH-1:0]              cmd_ready_o,
  input  logic                        bcast_valid_i,
  input  logic [CMD_WIDTH-1:0]        bcast_data_i,
  output logic                        bcast_ready_o,
  output logic                        frame_start_o,
  output logic [NCH*BITS_PER_CLK-1:0] dout_o
`ifdef SURF_CIN_FRAMER_COUNT_EN
  ,
  output logic [NCH*16-1:0]           cmd_count_o
`endif
);

  localparam int FRAME_LEN = frame_len(CMD_WIDTH, BITS_PER_CLK);
  localparam int PW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  if (CMD_WIDTH % BITS_PER_CLK != 0) begin : g_width_check
    $error("surf_cin_framer: CMD_WIDTH must be a multiple of BITS_PER_CLK");
  end

  logic [PW-1:0]  phase;
  logic           is_last;
  logic [NCH-1:0] pend_valid;
  logic [NCH-1:0] drain;
  logic [NCH-1:0] slot_free;
  logic [NCH-1:0] wr_en;
  logic           bcast_acc;

  // Sync cycle counts as phase 0, so the counter lands on 1 after it.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      phase <= '0;
    end else if (sync_i) begin
      phase <= PW'(1);
    end else if (is_last) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign is_last       = (phase == LAST);
  assign frame_start_o = rst_n_i & (phase == '0);

  assign drain         = {NCH{is_last}} & pend_valid & ~train_i;
  assign slot_free     = ~pend_valid | drain;
  assign bcast_ready_o = rst_n_i & (&slot_free);
  assign cmd_ready_o   = {NCH{rst_n_i & ~bcast_valid_i}} & slot_free;
  assign bcast_acc     = bcast_valid_i & bcast_ready_o;
  assign wr_en         = (cmd_valid_i & cmd_ready_o) | {NCH{bcast_acc}};

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic [CMD_WIDTH-1:0] wr_data;

    assign wr_data = bcast_acc ? bcast_data_i : cmd_data_i[c*CMD_WIDTH +: CMD_WIDTH];

    surf_cin_chan #(
      .CMD_WIDTH    (CMD_WIDTH),
      .BITS_PER_CLK (BITS_PER_CLK),
      .INV          (CIN_INV[c])
    ) u_chan (
      .sysclk_i   (sysclk_i),
      .rst_n_i    (rst_n_i),
      .load       (is_last),
      .train      (train_i[c]),
      .wr_en      (wr_en[c]),
      .wr_data    (wr_data),
      .pend_valid (pend_valid[c]),
      .slice      (dout_o[c*BITS_PER_CLK +: BITS_PER_CLK])
`ifdef SURF_CIN_FRAMER_COUNT_EN
      ,
      .count      (cmd_count_o[c*16 +: 16])
`endif
    );
  end

endmodule

// File: tb/tb_surf_cin_framer.sv
// Bench for surf_cin_framer: directed scenarios plus random traffic against a
// nibble-indexed frame model. Checks counters when SURF_CIN_FRAMER_COUNT_EN is set.
module tb_surf_cin_framer;

  localparam int NCH = 7;
  localparam int CW  = 32;
  localparam int BPC = 4;
  localparam int FL  = CW / BPC;
  localparam logic [NCH-1:0] INV = 7'b0000010;
  localparam logic [31:0] TRAIN = 32'hA55A6996;

  logic                sysclk_i = 1'b0;
  logic                rst_n_i;
  logic                sync_i;
  logic [NCH-1:0]      train_i;
  logic [NCH-1:0]      cmd_valid_i;
  logic [NCH*CW-1:0]   cmd_data_i;
  logic [NCH-1:0]      cmd_ready_o;
  logic                bcast_valid_i;
  logic [CW-1:0]       bcast_data_i;
  logic                bcast_ready_o;
  logic                frame_start_o;
  logic [NCH*BPC-1:0]  dout_o;
`ifdef SURF_CIN_FRAMER_COUNT_EN
  logic [NCH*16-1:0]   cmd_count_o;
`endif

  surf_cin_framer #(
    .NCH(NCH), .CMD_WIDTH(CW), .BITS_PER_CLK(BPC), .CIN_INV(INV)
  ) dut (
    .sysclk_i      (sysclk_i),
    .rst_n_i       (rst_n_i),
    .sync_i        (sync_i),
    .train_i       (train_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_ready_o   (cmd_ready_o),
    .bcast_valid_i (bcast_valid_i),
    .bcast_data_i  (bcast_data_i),
    .bcast_ready_o (bcast_ready_o),
    .frame_start_o (frame_start_o),
    .dout_o        (dout_o)
`ifdef SURF_CIN_FRAMER_COUNT_EN
    ,
    .cmd_count_o   (cmd_count_o)
`endif
  );

  always #5 sysclk_i = ~sysclk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: current word plus slice index into it (index >= FL means zero fill).
  int          m_phase;
  logic        m_pv   [NCH];
  logic [31:0] m_pd   [NCH];
  logic [31:0] m_word [NCH];
  int          m_k    [NCH];
  logic [15:0] m_cnt  [NCH];

  function automatic void model_reset();
    m_phase = 0;
    for (int c = 0; c < NCH; c++) begin
      m_pv[c] = 1'b0; m_pd[c] = '0; m_word[c] = '0; m_k[c] = FL; m_cnt[c] = '0;
    end
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w >> (4 * k);
    return t[3:0];
  endfunction

  // One clock: compare outputs at negedge, advance the model, return at posedge+1.
  task automatic cycle();
    logic              last, e_brdy, e_fs, bacc;
    logic [NCH-1:0]    free, e_rdy, wr;
    logic [NCH*BPC-1:0] e_dout;
    logic [31:0]       wd;
    @(negedge sysclk_i);
    last = (m_phase == FL - 1);
    for (int c = 0; c < NCH; c++) begin
      free[c] = !m_pv[c] || (last && !train_i[c]);
      e_dout[c*BPC +: BPC] = ((m_k[c] < FL) ? nib(m_word[c], m_k[c]) : 4'h0) ^ {4{INV[c]}};
    end
    e_brdy = rst_n_i & (&free);
    e_rdy  = {NCH{rst_n_i & ~bcast_valid_i}} & free;
    e_fs   = rst_n_i && (m_phase == 0);
    chk("dout", dout_o, e_dout);
    chk("cmd_ready", cmd_ready_o, e_rdy);
    chk("bcast_ready", bcast_ready_o, e_brdy);
    chk("frame_start", frame_start_o, e_fs);
`ifdef SURF_CIN_FRAMER_COUNT_EN
    for (int c = 0; c < NCH; c++) chk("cmd_count", cmd_count_o[c*16 +: 16], m_cnt[c]);
`endif
    if (!rst_n_i) begin
      model_reset();
    end else begin
      bacc = bcast_valid_i & e_brdy;
      for (int c = 0; c < NCH; c++) begin
        wr[c] = (cmd_valid_i[c] & e_rdy[c]) | bacc;
        wd    = bacc ? bcast_data_i : cmd_data_i[c*CW +: CW];
        if (last) begin
          m_k[c] = 0;
          if (train_i[c]) begin
            m_word[c] = TRAIN;
            if (wr[c]) begin m_pv[c] = 1'b1; m_pd[c] = wd; end
          end else if (m_pv[c]) begin
            m_word[c] = m_pd[c];
            m_cnt[c]  = m_cnt[c] + 16'd1;
            m_pv[c]   = wr[c];
            if (wr[c]) m_pd[c] = wd;
          end else if (wr[c]) begin
            m_word[c] = wd;
            m_cnt[c]  = m_cnt[c] + 16'd1;
          end else begin
            m_word[c] = '0;
          end
        end else begin
          if (m_k[c] < FL) m_k[c]++;
          if (wr[c]) begin m_pv[c] = 1'b1; m_pd[c] = wd; end
        end
      end
      m_phase = sync_i ? 1 : (last ? 0 : m_phase + 1);
    end
    @(posedge sysclk_i);
    #1;
  endtask

  // Advance at least one cycle, then until the model sits on phase p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_phase != p && n < 2 * FL);
    if (m_phase != p) chk("wait_phase", 64'(m_phase), 64'(p));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_cmd, b_cmd;
    rst_n_i = 1'b0; sync_i = 1'b0; train_i = '0; cmd_valid_i = '0; cmd_data_i = '0;
    bcast_valid_i = 1'b0; bcast_data_i = '0;
    @(posedge sysclk_i); #1;
    model_reset();
    cmd_valid_i = '1;
    bcast_valid_i = 1'b1;
    cycle();
    chk("rst_dout", dout_o, 64'h00000F0);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_bcast_ready", bcast_ready_o, 0);
    chk("rst_frame_start", frame_start_o, 0);
    cmd_valid_i = '0; bcast_valid_i = 1'b0;
    rst_n_i = 1'b1;
    cycle();

    // Idle sync: frame start 8 cycles after the sync cycle, then every 8
    wait_phase(2);
    sync_i = 1'b1; cycle(); sync_i = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("sync_fs", frame_start_o, 1);
    for (int i = 0; i < 8; i++) cycle();
    chk("sync_fs2", frame_start_o, 1);

    // Single command on ch2 at phase 3
    wait_phase(3);
    cmd_data_i[2*CW +: CW] = 32'h12345678;
    cmd_valid_i[2] = 1'b1;
    #1 chk("ch2_ready_hi", cmd_ready_o[2], 1);
    cycle();
    cmd_valid_i[2] = 1'b0;
    chk("ch2_ready_lo", cmd_ready_o[2], 0);
    wait_phase(0);
    for (int i = 0; i < FL; i++) begin
      chk("ch2_slice", dout_o[2*BPC +: BPC], 64'(8 - i));
      cycle();
    end

    // Training on ch0 with a command parked in its pending slot
    train_i[0] = 1'b1;
    wait_phase(2);
    cmd_data_i[0 +: CW] = 32'hCAFEF00D;
    cmd_valid_i[0] = 1'b1;
    cycle();
    cmd_valid_i[0] = 1'b0;
    wait_phase(0);
    for (int i = 0; i < FL; i++) begin
      chk("train_slice", dout_o[0 +: BPC], 64'(nib(TRAIN, i)));
      chk("train_ready0", cmd_ready_o[0], 0);
      cycle();
    end
    train_i[0] = 1'b0;
    wait_phase(0);
    for (int i = 0; i < FL; i++) begin
      chk("post_train_slice", dout_o[0 +: BPC], 64'(nib(32'hCAFEF00D, i)));
      cycle();
    end
    for (int i = 0; i < FL; i++) begin
      chk("no_dup_slice", dout_o[0 +: BPC], 0);
      cycle();
    end

    // Broadcast beats a simultaneous per-channel command
    wait_phase(5);
    bcast_valid_i = 1'b1; bcast_data_i = 32'hDEADBEEF;
    cmd_valid_i[4] = 1'b1; cmd_data_i[4*CW +: CW] = 32'h44444444;
    #1;
    chk("bc_ready4", cmd_ready_o[4], 0);
    chk("bc_bready", bcast_ready_o, 1);
    cycle();
    bcast_valid_i = 1'b0; cmd_valid_i[4] = 1'b0;
    wait_phase(0);
    for (int i = 0; i < FL; i++) begin
      for (int c = 0; c < NCH; c++)
        chk("bc_slice", dout_o[c*BPC +: BPC], 64'(nib(32'hDEADBEEF, i) ^ {4{INV[c]}}));
      cycle();
    end

    // Mid-frame sync truncates ch3's frame, queued command survives
    a_cmd = 32'h87654321; b_cmd = 32'h0FEDCBA9;
    wait_phase(6);
    cmd_data_i[3*CW +: CW] = a_cmd; cmd_valid_i[3] = 1'b1;
    cycle();
    cmd_data_i[3*CW +: CW] = b_cmd;
    cycle();
    cmd_valid_i[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pre_sync_slice", dout_o[3*BPC +: BPC], 64'(i + 1));
      cycle();
    end
    chk("sync_cycle_slice", dout_o[3*BPC +: BPC], 5);
    sync_i = 1'b1; cycle(); sync_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("trunc_slice", dout_o[3*BPC +: BPC], (i < 3) ? 64'(i + 6) : 64'h0);
      cycle();
    end
    chk("realign_fs", frame_start_o, 1);
    for (int i = 0; i < FL; i++) begin
      chk("queued_slice", dout_o[3*BPC +: BPC], 64'(nib(b_cmd, i)));
      cycle();
    end

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst_n_i = ($urandom_range(0, 499) != 0);
      sync_i = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (train_i[c]) begin
          if ($urandom_range(0, 7) == 0) train_i[c] = 1'b0;
        end else if ($urandom_range(0, 63) == 0) begin
          train_i[c] = 1'b1;
        end
        cmd_valid_i[c] = ($urandom_range(0, 3) == 0);
        cmd_data_i[c*CW +: CW] = $urandom();
      end
      bcast_valid_i = ($urandom_range(0, 15) == 0);
      bcast_data_i = $urandom();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
